// File: rtl/encoder_ctrl_pkg.sv
// Shared types and helpers for the encoder-block stage controllers.
//   mlp_sched_state_t : state encoding of the MLP token scheduler
//   row_offset()      : bit offset of element e of token t in a flattened matrix
package encoder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } mlp_sched_state_t;

  // Flattened layout: token-major, element-minor, data_width bits per element.
  function automatic int unsigned row_offset(input int unsigned t,
                                             input int unsigned e,
                                             input int unsigned emb_dim,
                                             input int unsigned data_width);
    return (t * emb_dim + e) * data_width;
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Per-transaction watchdog shared by the stage controllers.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart the count (start of a new transaction)
//   en         : count this cycle (controller is waiting and nothing arrived)
//   expired    : combinational; high in the waiting cycle in which the count
//                reaches TIMEOUT-1. TIMEOUT == 0 disables it permanently.
module ctrl_watchdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over counting.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Compare the post-increment value so the error lands TIMEOUT cycles after
  // the clear cycle.
  assign expired = (TIMEOUT != 0) && en && !clear &&
                   ((32'(count_q) + 32'd1) >= (TIMEOUT - 32'd1));

endmodule

// File: rtl/mlp_token_scheduler.sv
// Time-shares one mlp core across all SEQ_LEN tokens of an encoder block.
// Snapshots the LN2 matrix on start, issues one token per core transaction,
// gathers each result row into y_out and pulses done after the last token.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, abort          : run request (IDLE only) / synchronous cancel
//   x_in                  : LN2 matrix, flattened token-major
//   mlp_start/valid_in/x  : token issue to the core (mlp_x combinational)
//   mlp_valid_out, mlp_y  : core result
//   y_out, out_valid      : collected result matrix and its qualifier
//   token_idx, busy, done : progress / status
//   timeout_err           : sticky watchdog error, cleared by the next start
module mlp_token_scheduler
  import encoder_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned SEQ_LEN    = 8,
  parameter int unsigned EMB_DIM    = 8,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned IDX_W      = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic                                    abort,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]   x_in,
  output logic                                    mlp_start,
  output logic                                    mlp_valid_in,
  output logic [DATA_WIDTH*EMB_DIM-1:0]           mlp_x,
  input  logic                                    mlp_valid_out,
  input  logic [DATA_WIDTH*EMB_DIM-1:0]           mlp_y,
  output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0]   y_out,
  output logic [IDX_W-1:0]                        token_idx,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    out_valid,
  output logic                                    timeout_err
);

  localparam int unsigned ROW_W    = DATA_WIDTH * EMB_DIM;
  localparam int unsigned MAT_W    = ROW_W * SEQ_LEN;
  localparam int unsigned OFF_W    = (MAT_W > 1) ? $clog2(MAT_W) : 1;
  localparam int unsigned LAST_IDX = SEQ_LEN - 1;

  mlp_sched_state_t  state_q, state_d;
  logic [IDX_W-1:0]  token_idx_q, token_idx_d;
  logic [MAT_W-1:0]  snap_q, snap_d;
  logic [MAT_W-1:0]  y_q, y_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_err_q, timeout_err_d;

  logic [OFF_W-1:0]  cur_off;
  logic              wd_clear;
  logic              wd_en;
  logic              wd_expired;

  // Bit offset of the current token's row in both snapshot and result matrix.
  assign cur_off = OFF_W'(row_offset(32'(token_idx_q), 32'd0, EMB_DIM, DATA_WIDTH));

  assign wd_clear = (state_q == ISSUE);
  assign wd_en    = (state_q == WAIT) && !mlp_valid_out;

  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Next-state logic; abort overrides everything including a result write.
  always_comb begin
    state_d       = state_q;
    token_idx_d   = token_idx_q;
    snap_d        = snap_q;
    y_d           = y_q;
    out_valid_d   = out_valid_q;
    timeout_err_d = timeout_err_q;

    if (abort) begin
      state_d     = IDLE;
      token_idx_d = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            snap_d        = x_in;
            token_idx_d   = '0;
            out_valid_d   = 1'b0;
            timeout_err_d = 1'b0;
            state_d       = ISSUE;
          end
        end
        ISSUE: begin
          state_d = WAIT;
        end
        WAIT: begin
          if (mlp_valid_out) begin
            y_d[cur_off +: ROW_W] = mlp_y;
            if (token_idx_q == IDX_W'(LAST_IDX)) begin
              state_d = DONE;
            end else begin
              token_idx_d = token_idx_q + IDX_W'(1);
              state_d     = ISSUE;
            end
          end else if (wd_expired) begin
            timeout_err_d = 1'b1;
            state_d       = IDLE;
          end
        end
        DONE: begin
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      token_idx_q   <= '0;
      snap_q        <= '0;
      y_q           <= '0;
      out_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      token_idx_q   <= token_idx_d;
      snap_q        <= snap_d;
      y_q           <= y_d;
      out_valid_q   <= out_valid_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Core row is presented only while a token is in flight.
  always_comb begin
    mlp_x = '0;
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      mlp_x = snap_q[cur_off +: ROW_W];
    end
  end

  // Status decoded straight from the state register.
  assign mlp_start    = (state_q == ISSUE);
  assign mlp_valid_in = (state_q == ISSUE);
  assign busy         = (state_q == ISSUE) || (state_q == WAIT);
  assign done         = (state_q == DONE);
  assign token_idx    = token_idx_q;
  assign y_out        = y_q;
  assign out_valid    = out_valid_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_mlp_token_scheduler.sv
// Randomised scoreboard bench for mlp_token_scheduler with a behavioural
// core model (y = x + 1 per element, programmable latency per token).
module tb_mlp_token_scheduler;

  localparam int unsigned DW    = 16;
  localparam int unsigned SL    = 8;
  localparam int unsigned ED    = 8;
  localparam int unsigned TO    = 16;
  localparam int unsigned IW    = 3;
  localparam int unsigned ROW_W = DW * ED;
  localparam int unsigned MAT_W = ROW_W * SL;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [MAT_W-1:0] x_in;
  logic             mlp_start;
  logic             mlp_valid_in;
  logic [ROW_W-1:0] mlp_x;
  logic             mlp_valid_out;
  logic [ROW_W-1:0] mlp_y;
  logic [MAT_W-1:0] y_out;
  logic [IW-1:0]    token_idx;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic             timeout_err;

  mlp_token_scheduler #(
    .DATA_WIDTH (DW),
    .SEQ_LEN    (SL),
    .EMB_DIM    (ED),
    .TIMEOUT    (TO),
    .IDX_W      (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .x_in          (x_in),
    .mlp_start     (mlp_start),
    .mlp_valid_in  (mlp_valid_in),
    .mlp_x         (mlp_x),
    .mlp_valid_out (mlp_valid_out),
    .mlp_y         (mlp_y),
    .y_out         (y_out),
    .token_idx     (token_idx),
    .busy          (busy),
    .done          (done),
    .out_valid     (out_valid),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               kind;   // 0: done pulse, 1: watchdog error
    int               cyc;
    logic [MAT_W-1:0] y;
  } ev_t;

  ev_t              ev_q[$];
  logic [ROW_W-1:0] exp_x_q[$];
  int               exp_idx_q[$];
  int               lat_cfg[SL];     // <=0: core never answers that token
  logic [MAT_W-1:0] model_y;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_mat(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int t = 0; t < SL; t++) begin
        if (act[t*ROW_W +: ROW_W] !== exp[t*ROW_W +: ROW_W]) begin
          $display("FAIL %s row %0d got %h expected %h", name, t,
                   act[t*ROW_W +: ROW_W], exp[t*ROW_W +: ROW_W]);
          break;
        end
      end
    end
  endtask

  function automatic logic [ROW_W-1:0] plus_one(input logic [ROW_W-1:0] r);
    logic [ROW_W-1:0] o;
    for (int e = 0; e < ED; e++) o[e*DW +: DW] = r[e*DW +: DW] + DW'(1);
    return o;
  endfunction

  // Core model: answers each issued token after lat_cfg[token] cycles.
  initial begin : core
    bit               pend;
    int               cnt;
    logic [ROW_W-1:0] resp;
    logic [ROW_W-1:0] ex;
    int               ei;
    pend = 1'b0; cnt = 0; resp = '0;
    mlp_valid_out = 1'b0;
    mlp_y = '0;
    forever begin
      @(posedge clk); #1;
      mlp_valid_out = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mlp_valid_out = 1'b1;
            mlp_y = resp;
            pend = 1'b0;
          end
        end
        if (mlp_start) begin
          if (exp_x_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue got mlp_start=1 expected 0 (cycle %0d)", cyc);
          end else begin
            ex = exp_x_q.pop_front();
            ei = exp_idx_q.pop_front();
            chk("issue_row", 128'(mlp_x), 128'(ex));
            chk("issue_idx", 128'(token_idx), 128'(ei));
            chk("issue_flags", 128'({busy, out_valid, timeout_err, mlp_valid_in}), 128'(4'b1001));
          end
          if (lat_cfg[token_idx] > 0) begin
            pend = 1'b1;
            cnt  = lat_cfg[token_idx];
            resp = plus_one(mlp_x);
          end
        end
      end
    end
  end

  // Monitor: compares every done pulse / watchdog error against the scoreboard.
  initial begin : mon
    bit  prev_err;
    bit  ov_pend;
    ev_t ev;
    prev_err = 1'b0; ov_pend = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        prev_err = 1'b0; ov_pend = 1'b0;
        continue;
      end
      if (ov_pend) begin
        chk("post_done_flags", 128'({out_valid, busy, done}), 128'(3'b100));
        ov_pend = 1'b0;
      end
      if (done) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          ev = ev_q.pop_front();
          chk("done_kind", 128'(ev.kind), 128'(0));
          chk("done_cycle", 128'(cyc), 128'(ev.cyc));
          chk_mat("done_y", y_out, ev.y);
          ov_pend = 1'b1;
        end
      end
      if (timeout_err && !prev_err) begin
        if (ev_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_timeout got timeout_err=1 expected 0 (cycle %0d)", cyc);
        end else begin
          ev = ev_q.pop_front();
          chk("timeout_kind", 128'(ev.kind), 128'(1));
          chk("timeout_cycle", 128'(cyc), 128'(ev.cyc));
          chk("timeout_flags", 128'({busy, out_valid, done}), 128'(3'b000));
        end
      end
      prev_err = timeout_err;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Launch a run; predicts issue rows, result rows and the done/error cycle.
  task automatic run(input logic [MAT_W-1:0] x, input int stall_tok, input int abort_tok,
                     output int s);
    int  acc;
    ev_t ev;
    s = cyc;
    x_in = x;
    start = 1'b1;
    acc = s + 1;
    for (int t = 0; t < SL; t++) begin
      exp_x_q.push_back(x[t*ROW_W +: ROW_W]);
      exp_idx_q.push_back(t);
      if (t == stall_tok) begin
        ev.kind = 1; ev.cyc = acc + int'(TO); ev.y = '0;
        ev_q.push_back(ev);
        break;
      end
      if (t == abort_tok) break;
      model_y[t*ROW_W +: ROW_W] = plus_one(x[t*ROW_W +: ROW_W]);
      acc += 1 + lat_cfg[t];
    end
    if (stall_tok < 0 && abort_tok < 0) begin
      ev.kind = 0; ev.cyc = acc; ev.y = model_y;
      ev_q.push_back(ev);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (ev_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 128'(ev_q.size()), 128'(0));
    chk({name, "_issues"}, 128'(exp_x_q.size()), 128'(0));
    ev_q.delete(); exp_x_q.delete(); exp_idx_q.delete();
    tick(); tick();
  endtask

  function automatic logic [MAT_W-1:0] rand_mat();
    logic [MAT_W-1:0] m;
    for (int i = 0; i < int'(MAT_W / 32); i++) m[i*32 +: 32] = $urandom;
    return m;
  endfunction

  initial begin : guard
    #1000000;
    $display("FAIL global_time_limit got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [MAT_W-1:0] x;
    int               s;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; x_in = '0; model_y = '0;
    for (int t = 0; t < SL; t++) lat_cfg[t] = 3;
    #3;
    chk("reset_flags", 128'({busy, done, out_valid, timeout_err, mlp_start, mlp_valid_in, token_idx}), 128'(0));
    chk_mat("reset_y", y_out, '0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Nominal: element value t*8+e, L=3 -> done 33 cycles after start.
    for (int t = 0; t < SL; t++)
      for (int e = 0; e < ED; e++) x[(t*ED+e)*DW +: DW] = DW'(t*ED + e);
    run(x, -1, -1, s);
    drain("nominal", 100);
    chk("nominal_idle", 128'({out_valid, busy}), 128'(2'b10));

    // Snapshot isolation: x_in goes to all ones right after start.
    x = rand_mat();
    run(x, -1, -1, s);
    x_in = '1;
    drain("snapshot", 100);

    // Alternating latency 1/7 with start re-asserted mid-run.
    for (int t = 0; t < SL; t++) lat_cfg[t] = (t % 2 == 0) ? 1 : 7;
    run(rand_mat(), -1, -1, s);
    for (int k = 0; k < 30; k++) begin
      start = (k % 7 == 3);
      tick();
    end
    start = 1'b0;
    drain("varlat", 200);

    // Watchdog: token 2 never answered.
    for (int t = 0; t < SL; t++) lat_cfg[t] = 3;
    lat_cfg[2] = 0;
    run(rand_mat(), 2, -1, s);
    drain("watchdog", 200);
    chk("watchdog_state", 128'({busy, out_valid, timeout_err, done}), 128'(4'b0010));
    chk_mat("watchdog_y", y_out, model_y);
    lat_cfg[2] = 3;

    // Abort coincident with the token-5 result (valid at start+24 for L=3).
    run(rand_mat(), -1, 5, s);
    while (cyc < s + 24) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_state", 128'({busy, done, out_valid, mlp_start, token_idx}), 128'(0));
    tick(); tick();
    chk_mat("abort_y", y_out, model_y);
    drain("abort", 10);

    // Random runs with random latencies.
    for (int r = 0; r < 3; r++) begin
      for (int t = 0; t < SL; t++) lat_cfg[t] = int'($urandom_range(1, 7));
      run(rand_mat(), -1, -1, s);
      drain("random", 200);
    end

    // Asynchronous reset mid-WAIT, then a fresh nominal run.
    for (int t = 0; t < SL; t++) lat_cfg[t] = 3;
    run(rand_mat(), -1, -1, s);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 128'({busy, done, out_valid, timeout_err, mlp_start, mlp_valid_in, token_idx}), 128'(0));
    chk("async_reset_mlp_x", 128'(mlp_x), 128'(0));
    chk_mat("async_reset_y", y_out, '0);
    ev_q.delete(); exp_x_q.delete(); exp_idx_q.delete();
    model_y = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) tick();
    run(rand_mat(), -1, -1, s);
    drain("after_reset", 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
